mem_ctrl: RTL and testbench
===========================

# mem_ctrl

Parametrised multi-channel synchronous block-memory controller, successor to the single-port CPU memory model. Holds a DEPTH×DATA_W on-chip array and serves NCH requesters (CPU, video scanout, DMA…) through a round-robin arbiter. It performs one access per clock with a fixed one-cycle response latency. It sits between the c8088 core (and other masters) and block RAM in both simulation and synthesis.

## Interface
Parameters:
- NCH, 2, number of requester channels (1..8)
- ADDR_W, 20, address width per channel
- DATA_W, 8, data width
- DEPTH, 1048576, implemented words; must be ≤ 2**ADDR_W
- INIT_FILE, "", hex image loaded at elaboration by $readmemh; empty string means no load

Ports:
- clock  in  1  single system clock; all logic on posedge
- reset_n  in  1  synchronous, active-low reset
- req  in  NCH  per-channel access request (level)
- we  in  NCH  per-channel write enable, qualified by req
- addr  in  NCH*ADDR_W  channel i at bits [i*ADDR_W +: ADDR_W]
- wdata  in  NCH*DATA_W  channel i at bits [i*DATA_W +: DATA_W]
- gnt  out  NCH  one-hot combinational grant in the current cycle
- ack  out  NCH  one-hot registered completion, one cycle after gnt
- rdata  out  DATA_W  shared read data; valid only while any ack bit is high

## Operation
- Arbiter: in each cycle, gnt selects at most one channel with req=1. Round-robin search starts at pointer ptr.
- On the edge that ends a granted cycle:
  - ptr ← winner+1, mod NCH.
  - If ptr=NCH-1 wins, ptr wraps to 0.
  - With no request, ptr holds.
- Access happens on the edge that ends the gnt cycle, using that cycle's addr, we and wdata of the winner.
- Read: rdata ← mem[addr].
- Write: mem[addr] ← wdata. Read-first: rdata returns the old contents.
- Handshake:
  - A master holds req, addr, we and wdata stable until it sees its gnt bit.
  - A request is consumed on the gnt edge.
  - Keeping req high after gnt issues a new request. The next grant goes to another requester if one is pending.
- Out-of-range address (addr ≥ DEPTH): read returns all ones; write is dropped. ack still pulses.
- Single requester held high: it is granted every cycle, giving full throughput of one access per clock.
- Memory contents are not affected by reset.

## Timing
- Reset (reset_n=0 at an edge): ack=0, rdata=0, ptr=0.
- gnt is combinational. During reset, gnt is forced to 0 and no access occurs.
- Reset mid-operation: a grant issued in the cycle the reset edge samples is discarded. No write occurs and no ack is produced.
- Latency: gnt in cycle T → ack and rdata in cycle T+1. ack is high for exactly one cycle per grant.
- Back-to-back grants give back-to-back acks with no bubble.
- rdata holds its last value when no ack is high.
- A write by channel A in cycle T followed by a read of the same address by channel B in cycle T+1: B sees the new data at T+2.

## Configuration
- MEM_CTRL_PRIO_EN defined:
  - Channel 0 has fixed top priority. It wins whenever req[0]=1.
  - Channels 1..NCH-1 round-robin among themselves. ptr ranges over 1..NCH-1 and resets to 1.
  - Intended for a latency-critical CPU on channel 0.
- MEM_CTRL_PRIO_EN undefined: pure round-robin over all NCH channels, as described above.

## Structure
- Package mem_ctrl_pkg holds:
  - default ADDR_W, DATA_W and DEPTH constants
  - the out-of-range fill value (all ones)
  - a function for the channel-slice index
- Sub-module rr_arbiter(NCH) contains the pointer register and the combinational one-hot grant. Its inputs are req and the priority mode; its outputs are gnt and the winner index.
- The memory array, access register and ack register live in mem_ctrl.

## Test plan
- Reset, then write: channel 0 writes 0x5A to 0x00010 → gnt[0] in T, ack[0] in T+1. A following read of 0x00010 returns rdata=0x5A.
- Read-first: preload mem[0x00020]=0x11. Channel 1 writes 0x22 there → the write ack shows rdata=0x11. A subsequent read returns 0x22.
- Contention, NCH=2, no macro: req=2'b11 held for 6 cycles → gnt order 0,1,0,1,0,1, with ack following one cycle later each time.
- MEM_CTRL_PRIO_EN, NCH=3: req=3'b111 held → gnt[0] every cycle. Dropping req[0] → gnt alternates 1,2.
- Out of range, DEPTH=1024: read at addr 0x00400 → rdata=0xFF, ack pulses. A write to 0x00400 leaves mem[0x000] unchanged.
- Reset mid-operation: assert reset_n=0 in a gnt cycle of a write of 0x77 to 0x00030 → no ack, and mem[0x00030] keeps its old value. After release, ack=0, rdata=0 and ptr restarts.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared constants and helpers for the multi-channel memory controller.
//   DefAddrW / DefDataW / DefDepth : default geometry
//   OorFill                        : read value returned for out-of-range addresses
//   chan_lo()                      : low bit index of a channel's slice in a packed bus
package mem_ctrl_pkg;

    localparam int unsigned DefAddrW = 20;
    localparam int unsigned DefDataW = 8;
    localparam int unsigned DefDepth = 1048576;

    // Wide enough for any sensible DATA_W; users slice the low DATA_W bits.
    localparam logic [63:0] OorFill = '1;

    function automatic int unsigned chan_lo(input int unsigned ch, input int unsigned width);
        return ch * width;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin request arbiter with optional fixed priority for channel 0.
//   clk_i      : clock
//   rst_ni     : synchronous active-low reset; forces gnt_o to zero while low
//   req_i      : per-channel requests
//   prio_en_i  : 1 = channel 0 always wins, channels 1..NCH-1 rotate among themselves
//   gnt_o      : one-hot combinational grant
//   winner_o   : index of the granted channel (valid when gnt_o != 0)
module rr_arbiter #(
    parameter int unsigned NCH  = 2,
    parameter int unsigned PtrW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [NCH-1:0]  req_i,
    input  logic            prio_en_i,
    output logic [NCH-1:0]  gnt_o,
    output logic [PtrW-1:0] winner_o
);

    // Size of the rotating group in priority mode; kept nonzero for NCH=1.
    localparam int unsigned NSub = (NCH > 1) ? NCH - 1 : 1;

    logic [PtrW-1:0] ptr_q, ptr_d, ptr_rst;
    int unsigned     cand;
    logic            found;

    always_comb begin
        gnt_o    = '0;
        winner_o = '0;
        found    = 1'b0;
        cand     = 0;
        if (rst_ni) begin
            if (prio_en_i && req_i[0]) begin
                gnt_o[0] = 1'b1;
            end else begin
                for (int unsigned k = 0; k < NCH; k++) begin
                    if (prio_en_i) begin
                        // Rotate over 1..NCH-1; the extra NSub keeps the sum non-negative.
                        cand = 1 + ((32'(ptr_q) + NSub - 1 + k) % NSub);
                    end else begin
                        cand = (32'(ptr_q) + k) % NCH;
                    end
                    if (!found && cand < NCH && req_i[cand[PtrW-1:0]]) begin
                        found                   = 1'b1;
                        gnt_o[cand[PtrW-1:0]]   = 1'b1;
                        winner_o                = cand[PtrW-1:0];
                    end
                end
            end
        end
    end

    always_comb begin
        ptr_rst = (prio_en_i && NCH > 1) ? PtrW'(1) : '0;
        ptr_d   = ptr_q;
        if (|gnt_o) begin
            if (prio_en_i) begin
                // Channel 0 wins do not disturb the rotation among the others.
                if (winner_o != '0) begin
                    ptr_d = (winner_o == PtrW'(NCH - 1)) ? PtrW'(1) : winner_o + PtrW'(1);
                end
            end else begin
                ptr_d = (winner_o == PtrW'(NCH - 1)) ? '0 : winner_o + PtrW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr_q <= ptr_rst;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: NCH-channel synchronous block-memory controller, one access per clock,
// one-cycle response latency, read-first on writes.
//   clock   : system clock (posedge)
//   reset_n : synchronous active-low reset (memory contents are kept)
//   req/we  : per-channel request and write enable
//   addr    : packed channel addresses, channel i at [i*ADDR_W +: ADDR_W]
//   wdata   : packed channel write data, channel i at [i*DATA_W +: DATA_W]
//   gnt     : one-hot combinational grant
//   ack     : one-hot registered completion, one cycle after gnt
//   rdata   : shared read data, valid while any ack bit is high
// Build option: define MEM_CTRL_PRIO_EN to give channel 0 fixed top priority.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned NCH       = 2,
    parameter int unsigned ADDR_W    = DefAddrW,
    parameter int unsigned DATA_W    = DefDataW,
    parameter int unsigned DEPTH     = DefDepth,
    parameter string       INIT_FILE = ""
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [NCH-1:0]        req,
    input  logic [NCH-1:0]        we,
    input  logic [NCH*ADDR_W-1:0] addr,
    input  logic [NCH*DATA_W-1:0] wdata,
    output logic [NCH-1:0]        gnt,
    output logic [NCH-1:0]        ack,
    output logic [DATA_W-1:0]     rdata
);

`ifdef MEM_CTRL_PRIO_EN
    localparam logic PrioEn = 1'b1;
`else
    localparam logic PrioEn = 1'b0;
`endif

    localparam int unsigned PtrW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [PtrW-1:0]   winner;
    logic              granted;
    logic [ADDR_W-1:0] addr_sel;
    logic [DATA_W-1:0] wdata_sel;
    logic              we_sel;
    logic              in_range;
    logic [IdxW-1:0]   mem_idx;
    logic [NCH-1:0]    ack_q, ack_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    rr_arbiter #(
        .NCH (NCH)
    ) u_arb (
        .clk_i     (clock),
        .rst_ni    (reset_n),
        .req_i     (req),
        .prio_en_i (PrioEn),
        .gnt_o     (gnt),
        .winner_o  (winner)
    );

    always_comb begin
        granted   = |gnt;
        addr_sel  = addr[chan_lo(32'(winner), ADDR_W) +: ADDR_W];
        wdata_sel = wdata[chan_lo(32'(winner), DATA_W) +: DATA_W];
        we_sel    = we[winner];
        in_range  = {1'b0, addr_sel} < (ADDR_W + 1)'(DEPTH);
        mem_idx   = addr_sel[IdxW-1:0];

        ack_d   = gnt;
        rdata_d = rdata_q;
        if (granted) begin
            // Sampled on the same edge as the write, so a write returns the old word.
            rdata_d = in_range ? mem[mem_idx] : OorFill[DATA_W-1:0];
        end
    end

    // gnt is already zero during reset, so no write can slip through.
    always_ff @(posedge clock) begin
        if (granted && we_sel && in_range) begin
            mem[mem_idx] <= wdata_sel;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            ack_q   <= '0;
            rdata_q <= '0;
        end else begin
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
        end
    end

    assign ack   = ack_q;
    assign rdata = rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed + randomized checks of mem_ctrl against a behavioural model.
module tb_mem_ctrl;

    localparam int NCH    = 3;
    localparam int ADDR_W = 20;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 1024;

    logic                  clock = 1'b0;
    logic                  reset_n;
    logic [NCH-1:0]        req, we;
    logic [NCH*ADDR_W-1:0] addr;
    logic [NCH*DATA_W-1:0] wdata;
    logic [NCH-1:0]        gnt, ack;
    logic [DATA_W-1:0]     rdata;

    mem_ctrl #(
        .NCH    (NCH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .req     (req),
        .we      (we),
        .addr    (addr),
        .wdata   (wdata),
        .gnt     (gnt),
        .ack     (ack),
        .rdata   (rdata)
    );

    always #5 clock = ~clock;

    // Reference model state
    bit          prio;
    int          m_ptr;
    logic [7:0]  m_mem [DEPTH];
    bit          m_kn  [DEPTH];
    logic [7:0]  m_rdata;
    bit          m_rkn;
    logic [2:0]  m_ack;

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Winner = requester closest to the pointer going upward (cyclic distance).
    function automatic int model_pick(input logic [2:0] r);
        int best = -1;
        int bd   = 1000;
        int d;
        if (prio && r[0]) return 0;
        for (int c = (prio ? 1 : 0); c < NCH; c++) begin
            if (r[c]) begin
                d = prio ? (c - m_ptr + (NCH - 1)) % (NCH - 1) : (c - m_ptr + NCH) % NCH;
                if (d < bd) begin
                    bd   = d;
                    best = c;
                end
            end
        end
        return best;
    endfunction

    function automatic logic [59:0] pa(input int a0, input int a1, input int a2);
        return {20'(a2), 20'(a1), 20'(a0)};
    endfunction

    function automatic logic [23:0] pd(input int d0, input int d1, input int d2);
        return {8'(d2), 8'(d1), 8'(d0)};
    endfunction

    task automatic cyc(input logic rn, input logic [2:0] r, input logic [2:0] w,
                       input logic [59:0] a, input logic [23:0] d, input string tag);
        int         win;
        int         ai;
        logic [19:0] aw;
        @(negedge clock);
        reset_n = rn;
        req     = r;
        we      = w;
        addr    = a;
        wdata   = d;
        #1;
        win = rn ? model_pick(r) : -1;
        check({tag, ":gnt"}, 32'(gnt), (win >= 0) ? (32'(1) << win) : 32'(0));
        if (!rn) begin
            m_ack   = '0;
            m_rdata = '0;
            m_rkn   = 1'b1;
            m_ptr   = prio ? 1 : 0;
        end else if (win >= 0) begin
            m_ack = 3'(1 << win);
            aw    = a[win*20 +: 20];
            ai    = int'(aw);
            if (ai < DEPTH) begin
                m_rdata = m_mem[ai];
                m_rkn   = m_kn[ai];
                if (w[win]) begin
                    m_mem[ai] = d[win*8 +: 8];
                    m_kn[ai]  = 1'b1;
                end
            end else begin
                m_rdata = 8'hFF;
                m_rkn   = 1'b1;
            end
            if (prio) begin
                if (win > 0) m_ptr = win % (NCH - 1) + 1;
            end else begin
                m_ptr = (win + 1) % NCH;
            end
        end else begin
            m_ack = '0;
        end
        @(posedge clock);
        #1;
        check({tag, ":ack"}, 32'(ack), 32'(m_ack));
        if (m_rkn) check({tag, ":rdata"}, 32'(rdata), 32'(m_rdata));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef MEM_CTRL_PRIO_EN
        prio = 1'b1;
`else
        prio = 1'b0;
`endif
        m_ptr   = prio ? 1 : 0;
        m_rdata = '0;
        m_rkn   = 1'b0;
        m_ack   = '0;
        for (int i = 0; i < DEPTH; i++) m_kn[i] = 1'b0;
        reset_n = 1'b0;
        req     = '0;
        we      = '0;
        addr    = '0;
        wdata   = '0;

        // Reset state
        cyc(1'b0, 3'b000, 3'b000, pa(0, 0, 0), pd(0, 0, 0), "reset0");
        cyc(1'b0, 3'b111, 3'b111, pa(1, 2, 3), pd(1, 2, 3), "reset1");

        // Fill memory at full throughput through channel 0
        for (int i = 0; i < DEPTH; i++)
            cyc(1'b1, 3'b001, 3'b001, pa(i, 0, 0), pd($urandom, 0, 0), "init");

        // Write then read back
        cyc(1'b1, 3'b001, 3'b001, pa('h10, 0, 0), pd('h5A, 0, 0), "wr5a");
        cyc(1'b1, 3'b001, 3'b000, pa('h10, 0, 0), pd(0, 0, 0), "rd5a");

        // Read-first
        cyc(1'b1, 3'b001, 3'b001, pa('h20, 0, 0), pd('h11, 0, 0), "pre11");
        cyc(1'b1, 3'b010, 3'b010, pa(0, 'h20, 0), pd(0, 'h22, 0), "rfirst");
        cyc(1'b1, 3'b010, 3'b000, pa(0, 'h20, 0), pd(0, 0, 0), "rd22");

        // Contention between channels 0 and 1
        for (int i = 0; i < 6; i++)
            cyc(1'b1, 3'b011, 3'b000, pa(i, i + 8, 0), pd(0, 0, 0), "cont01");

        // All three, then channel 0 dropped
        for (int i = 0; i < 6; i++)
            cyc(1'b1, 3'b111, 3'b000, pa(i, i + 1, i + 2), pd(0, 0, 0), "cont012");
        for (int i = 0; i < 4; i++)
            cyc(1'b1, 3'b110, 3'b000, pa(0, i, i + 5), pd(0, 0, 0), "cont12");

        // Write by A followed by read of the same word by B
        cyc(1'b1, 3'b001, 3'b001, pa('h40, 0, 0), pd('h3C, 0, 0), "wrA");
        cyc(1'b1, 3'b100, 3'b000, pa(0, 0, 'h40), pd(0, 0, 0), "rdB");

        // Out of range
        cyc(1'b1, 3'b100, 3'b000, pa(0, 0, 'h400), pd(0, 0, 0), "oor_rd");
        cyc(1'b1, 3'b001, 3'b001, pa('h400, 0, 0), pd('h99, 0, 0), "oor_wr");
        cyc(1'b1, 3'b001, 3'b000, pa('h000, 0, 0), pd(0, 0, 0), "oor_chk");

        // Reset in the cycle of a write grant
        cyc(1'b1, 3'b010, 3'b000, pa(0, 5, 0), pd(0, 0, 0), "pre_rst");
        cyc(1'b0, 3'b001, 3'b001, pa('h30, 0, 0), pd('h77, 0, 0), "rst_wr");
        cyc(1'b1, 3'b111, 3'b000, pa('h30, 1, 2), pd(0, 0, 0), "post_rst");
        cyc(1'b1, 3'b001, 3'b000, pa('h30, 0, 0), pd(0, 0, 0), "rd30");

        // Randomized traffic, including out-of-range addresses
        for (int i = 0; i < 300; i++)
            cyc(1'b1, 3'($urandom), 3'($urandom),
                pa($urandom_range(1100), $urandom_range(1100), $urandom_range(1100)),
                pd($urandom, $urandom, $urandom), "rand");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
